mem_arbiter: RTL and testbench

Two-port arbiter that shares the single unified memory interface of the multi-cycle MIPS system between the CPU (port 0: fetch and load/store) and a secondary master (port 1: program loader/DMA). It sits between the mips top level and the memory. It accepts one transaction at a time, selects a winner by fixed-priority or round-robin policy, presents the command to memory with a ready handshake, and routes read data back to the winner. In fixed-priority mode, a starvation guard prevents port 1 from being locked out indefinitely.

---
 rtl/mem_arbiter_if.sv | 42 ++++
 rtl/mem_arbiter.sv | 99 +++++++++
 tb/tb_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Requester, memory and status signals of the two-port memory arbiter.
// slave is the arbiter's view; master is the view of requesters and memory.
interface mem_arbiter_if #(
    parameter int AW = 64,
    parameter int DW = 64
);
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          gnt0;
    logic          rvalid0;
    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          gnt1;
    logic          rvalid1;
    logic [DW-1:0] rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
        input  mem_ready, mem_rvalid, mem_rdata,
        output gnt0, rvalid0, gnt1, rvalid1, rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
        output mem_ready, mem_rvalid, mem_rdata,
        input  gnt0, rvalid0, gnt1, rvalid1, rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one memory interface between the CPU (port 0)
// and a loader/DMA master (port 1); one transaction in flight at a time.
//
// state   | meaning
// IDLE    | no transaction; arbitrate among pending requests
// ISSUE   | mem_req held with the latched command until mem_ready
// WAIT_RD | read accepted; waiting for mem_rvalid
module mem_arbiter #(
    parameter int          AW           = 64,
    parameter int          DW           = 64,
    parameter bit          FIXED_PRIO   = 1'b1,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input logic            clk,
    input logic            reset,
    mem_arbiter_if.slave   bus
);
    localparam int SW = (STARVE_LIMIT == 0) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

    state_t        state;
    logic          winner;
    logic          last_winner;
    logic [SW-1:0] starve_cnt;
    logic          pick;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // With the guard disabled the counter never leaves 0 and never forces port 1.
    always_comb begin
        pick = bus.req1;
        if (bus.req0 && bus.req1) begin
            if (FIXED_PRIO) pick = (STARVE_LIMIT != 0) && (starve_cnt == SLIM);
            else            pick = ~last_winner;
        end
        sel_we    = pick ? bus.we1    : bus.we0;
        sel_addr  = pick ? bus.addr1  : bus.addr0;
        sel_wdata = pick ? bus.wdata1 : bus.wdata0;
    end

    assign bus.gnt0 = (state == ISSUE) && bus.mem_ready && !winner;
    assign bus.gnt1 = (state == ISSUE) && bus.mem_ready &&  winner;
    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            winner        <= 1'b0;
            last_winner   <= 1'b1;
            starve_cnt    <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.rdata     <= '0;
            bus.rvalid0   <= 1'b0;
            bus.rvalid1   <= 1'b0;
        end else begin
            bus.rvalid0 <= 1'b0;
            bus.rvalid1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        winner        <= pick;
                        last_winner   <= pick;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= sel_we;
                        bus.mem_addr  <= sel_addr;
                        bus.mem_wdata <= sel_wdata;
                        if (pick)
                            starve_cnt <= '0;
                        else if (bus.req1 && starve_cnt != SLIM)
                            starve_cnt <= starve_cnt + 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.mem_ready) begin
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                        state       <= bus.mem_we ? IDLE : WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (bus.mem_rvalid) begin
                        bus.rdata   <= bus.mem_rdata;
                        bus.rvalid0 <= !winner;
                        bus.rvalid1 <= winner;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three configurations (fixed priority with guard 3,
// round-robin, fixed priority without guard) driven by shared stimulus.
module tb_mem_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          req0, we0, req1, we1, mem_ready, mem_rvalid;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1, mem_rdata;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus_fp ();
    mem_arbiter_if #(.AW(AW), .DW(DW)) bus_rr ();
    mem_arbiter_if #(.AW(AW), .DW(DW)) bus_ns ();

    assign bus_fp.req0 = req0; assign bus_fp.we0 = we0; assign bus_fp.addr0 = addr0; assign bus_fp.wdata0 = wdata0;
    assign bus_fp.req1 = req1; assign bus_fp.we1 = we1; assign bus_fp.addr1 = addr1; assign bus_fp.wdata1 = wdata1;
    assign bus_fp.mem_ready = mem_ready; assign bus_fp.mem_rvalid = mem_rvalid; assign bus_fp.mem_rdata = mem_rdata;
    assign bus_rr.req0 = req0; assign bus_rr.we0 = we0; assign bus_rr.addr0 = addr0; assign bus_rr.wdata0 = wdata0;
    assign bus_rr.req1 = req1; assign bus_rr.we1 = we1; assign bus_rr.addr1 = addr1; assign bus_rr.wdata1 = wdata1;
    assign bus_rr.mem_ready = mem_ready; assign bus_rr.mem_rvalid = mem_rvalid; assign bus_rr.mem_rdata = mem_rdata;
    assign bus_ns.req0 = req0; assign bus_ns.we0 = we0; assign bus_ns.addr0 = addr0; assign bus_ns.wdata0 = wdata0;
    assign bus_ns.req1 = req1; assign bus_ns.we1 = we1; assign bus_ns.addr1 = addr1; assign bus_ns.wdata1 = wdata1;
    assign bus_ns.mem_ready = mem_ready; assign bus_ns.mem_rvalid = mem_rvalid; assign bus_ns.mem_rdata = mem_rdata;

    mem_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1'b1), .STARVE_LIMIT(3)) dut_fp (.clk(clk), .reset(rst), .bus(bus_fp));
    mem_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1'b0), .STARVE_LIMIT(8)) dut_rr (.clk(clk), .reset(rst), .bus(bus_rr));
    mem_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1'b1), .STARVE_LIMIT(0)) dut_ns (.clk(clk), .reset(rst), .bus(bus_ns));

    typedef struct packed {
        logic gnt0, gnt1, rvalid0, rvalid1, mem_req, mem_we, busy;
        logic [AW-1:0] mem_addr;
        logic [DW-1:0] mem_wdata;
        logic [DW-1:0] rdata;
    } obs_t;
    obs_t obs [3];
    assign obs[0] = {bus_fp.gnt0, bus_fp.gnt1, bus_fp.rvalid0, bus_fp.rvalid1, bus_fp.mem_req, bus_fp.mem_we, bus_fp.busy, bus_fp.mem_addr, bus_fp.mem_wdata, bus_fp.rdata};
    assign obs[1] = {bus_rr.gnt0, bus_rr.gnt1, bus_rr.rvalid0, bus_rr.rvalid1, bus_rr.mem_req, bus_rr.mem_we, bus_rr.busy, bus_rr.mem_addr, bus_rr.mem_wdata, bus_rr.rdata};
    assign obs[2] = {bus_ns.gnt0, bus_ns.gnt1, bus_ns.rvalid0, bus_ns.rvalid1, bus_ns.mem_req, bus_ns.mem_we, bus_ns.busy, bus_ns.mem_addr, bus_ns.mem_wdata, bus_ns.rdata};

    string iname [3] = '{"fp", "rr", "ns"};
    int    m_fp  [3] = '{1, 0, 1};
    int    m_sl  [3] = '{3, 8, 0};

    // Transaction-level reference: an optional command waiting for acceptance,
    // an optional read waiting for data, and what the last read returned.
    bit            cmd_pending  [3];
    bit            data_pending [3];
    bit            owner        [3];
    bit            prev_owner   [3];
    int            starve       [3];
    bit            cmd_we       [3];
    logic [AW-1:0] cmd_addr     [3];
    logic [DW-1:0] cmd_wdata    [3];
    logic [DW-1:0] last_rdata   [3];
    int            rv_port      [3];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;
    bit log_on   = 1'b0;
    int gq [3][$];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            cmd_pending[i] = 0; data_pending[i] = 0; owner[i] = 0; prev_owner[i] = 1;
            starve[i] = 0; cmd_we[i] = 0; cmd_addr[i] = '0; cmd_wdata[i] = '0;
            last_rdata[i] = '0; rv_port[i] = -1;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            int rvn = -1;
            if (!cmd_pending[i] && !data_pending[i]) begin
                if (req0 || req1) begin
                    bit w;
                    if (req0 && req1)
                        w = (m_fp[i] != 0) ? (m_sl[i] != 0 && starve[i] == m_sl[i]) : !prev_owner[i];
                    else
                        w = req1;
                    if (w) starve[i] = 0;
                    else if (req1 && starve[i] < m_sl[i]) starve[i] = starve[i] + 1;
                    owner[i] = w; prev_owner[i] = w;
                    cmd_we[i]    = w ? we1 : we0;
                    cmd_addr[i]  = w ? addr1 : addr0;
                    cmd_wdata[i] = w ? wdata1 : wdata0;
                    cmd_pending[i] = 1;
                end
            end else if (cmd_pending[i]) begin
                if (mem_ready) begin
                    cmd_pending[i]  = 0;
                    data_pending[i] = !cmd_we[i];
                end
            end else if (mem_rvalid) begin
                last_rdata[i]   = mem_rdata;
                rvn             = owner[i] ? 1 : 0;
                data_pending[i] = 0;
            end
            rv_port[i] = rvn;
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else      model_step();
    end

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_one(input int i);
        string p = iname[i];
        cmp({p, ".gnt0"},      obs[i].gnt0,      cmd_pending[i] && mem_ready && !owner[i]);
        cmp({p, ".gnt1"},      obs[i].gnt1,      cmd_pending[i] && mem_ready &&  owner[i]);
        cmp({p, ".rvalid0"},   obs[i].rvalid0,   rv_port[i] == 0);
        cmp({p, ".rvalid1"},   obs[i].rvalid1,   rv_port[i] == 1);
        cmp({p, ".mem_req"},   obs[i].mem_req,   cmd_pending[i]);
        cmp({p, ".mem_we"},    obs[i].mem_we,    cmd_pending[i] && cmd_we[i]);
        cmp({p, ".busy"},      obs[i].busy,      cmd_pending[i] || data_pending[i]);
        cmp({p, ".mem_addr"},  obs[i].mem_addr,  cmd_addr[i]);
        cmp({p, ".mem_wdata"}, obs[i].mem_wdata, cmd_wdata[i]);
        cmp({p, ".rdata"},     obs[i].rdata,     last_rdata[i]);
    endtask

    always @(negedge clk) begin
        #2;
        if (chk_on) for (int i = 0; i < 3; i++) check_one(i);
        if (log_on) for (int i = 0; i < 3; i++) begin
            if (obs[i].gnt0) gq[i].push_back(0);
            if (obs[i].gnt1) gq[i].push_back(1);
        end
    end

    task automatic quiet_inputs();
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    endtask

    task automatic pin(input string name, input int sel, input logic [63:0] exp);
        for (int i = 0; i < 3; i++) begin
            logic [63:0] a;
            case (sel)
                0: a = 64'(obs[i].gnt0);
                1: a = 64'(obs[i].gnt1);
                2: a = 64'(obs[i].rvalid0);
                3: a = 64'(obs[i].rvalid1);
                4: a = 64'(obs[i].mem_req);
                5: a = 64'(obs[i].mem_we);
                6: a = 64'(obs[i].busy);
                7: a = obs[i].mem_addr;
                default: a = obs[i].rdata;
            endcase
            cmp({"pin.", iname[i], ".", name}, a, exp);
        end
    endtask

    int exp_ord [3][8] = '{'{0, 0, 0, 1, 0, 0, 0, 1}, '{0, 1, 0, 1, 0, 1, 0, 1}, '{0, 0, 0, 0, 0, 0, 0, 0}};
    bit g0_prev, g1_prev;

    initial begin
        quiet_inputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        #3;
        pin("rst.busy", 6, 0); pin("rst.mem_addr", 7, 0); pin("rst.rdata", 8, 0);
        @(negedge clk); rst = 1'b1;

        // single write on port 0 with memory always ready
        @(negedge clk);
        req0 = 1; we0 = 1; addr0 = 64'h40; wdata0 = 64'hDEAD; mem_ready = 1;
        @(negedge clk); #3;
        pin("w.mem_req", 4, 1); pin("w.mem_we", 5, 1); pin("w.mem_addr", 7, 64'h40);
        pin("w.gnt0", 0, 1); pin("w.gnt1", 1, 0);
        req0 = 0;
        @(negedge clk); #3;
        pin("w.busy_after", 6, 0); pin("w.mem_req_after", 4, 0);

        // read on port 1 with three wait states and delayed data
        @(negedge clk);
        req1 = 1; we1 = 0; addr1 = 64'h100; mem_ready = 0;
        @(negedge clk); #3;
        pin("r.mem_req", 4, 1); pin("r.mem_addr", 7, 64'h100);
        @(negedge clk);
        @(negedge clk); #3;
        pin("r.gnt1_wait", 1, 0);
        @(negedge clk); mem_ready = 1; #3;
        pin("r.gnt1", 1, 1); pin("r.addr_held", 7, 64'h100);
        req1 = 0;
        @(negedge clk); mem_ready = 0;
        @(negedge clk); mem_rvalid = 1; mem_rdata = 64'h1234;
        @(negedge clk); mem_rvalid = 0; mem_rdata = '0; #3;
        pin("r.rvalid1", 3, 1); pin("r.rvalid0", 2, 0); pin("r.rdata", 8, 64'h1234);
        @(negedge clk); #3;
        pin("r.rvalid1_end", 3, 0); pin("r.busy_end", 6, 0); pin("r.rdata_hold", 8, 64'h1234);

        // continuous contention: grant order per configuration
        @(negedge clk); rst = 0;
        @(negedge clk); rst = 1;
        @(negedge clk);
        req0 = 1; req1 = 1; we0 = 1; we1 = 1; mem_ready = 1;
        addr0 = {$urandom, $urandom}; addr1 = {$urandom, $urandom};
        wdata0 = {$urandom, $urandom}; wdata1 = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) gq[i].delete();
        log_on = 1;
        repeat (16) @(negedge clk);
        #3; log_on = 0; req0 = 0; req1 = 0;
        for (int i = 0; i < 3; i++) begin
            cmp({"order.", iname[i], ".count"}, 64'(gq[i].size() >= 8), 1);
            for (int k = 0; k < 8; k++)
                if (k < gq[i].size())
                    cmp($sformatf("order.%s[%0d]", iname[i], k), 64'(gq[i][k]), 64'(exp_ord[i][k]));
        end
        repeat (2) @(negedge clk);

        // reset while a read waits for data; late data must be ignored
        req0 = 1; we0 = 0; addr0 = 64'h80; mem_ready = 1;
        @(negedge clk); #3; req0 = 0;
        @(negedge clk); mem_ready = 0; #3;
        rst = 0; #1;
        pin("mr.busy", 6, 0); pin("mr.mem_req", 4, 0); pin("mr.mem_addr", 7, 0);
        @(negedge clk); rst = 1;
        @(negedge clk); mem_rvalid = 1; mem_rdata = {$urandom, $urandom};
        @(negedge clk); mem_rvalid = 0; #3;
        pin("mr.rvalid0", 2, 0); pin("mr.rvalid1", 3, 0); pin("mr.rdata", 8, 0);
        req0 = 1; req1 = 1; we0 = 1; we1 = 1; mem_ready = 1;
        @(negedge clk); #3;
        pin("mr.first_gnt0", 0, 1); pin("mr.first_gnt1", 1, 0);
        req0 = 0; req1 = 0;
        repeat (2) @(negedge clk);

        // randomized traffic; requesters follow the hold-until-grant rule of the fp instance
        quiet_inputs();
        g0_prev = 0; g1_prev = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!req0 || g0_prev) begin
                req0 = ($urandom_range(0, 2) != 0); we0 = $urandom_range(0, 1) != 0;
                addr0 = {$urandom, $urandom}; wdata0 = {$urandom, $urandom};
            end
            if (!req1 || g1_prev) begin
                req1 = ($urandom_range(0, 2) != 0); we1 = $urandom_range(0, 1) != 0;
                addr1 = {$urandom, $urandom}; wdata1 = {$urandom, $urandom};
            end
            mem_ready  = $urandom_range(0, 9) < 6;
            mem_rvalid = $urandom_range(0, 9) < 3;
            mem_rdata  = {$urandom, $urandom};
            g0_prev = cmd_pending[0] && mem_ready && !owner[0];
            g1_prev = cmd_pending[0] && mem_ready &&  owner[0];
            if (c == 1500) begin
                #3; rst = 0;
                @(negedge clk); rst = 1; req0 = 0; req1 = 0;
                g0_prev = 0; g1_prev = 0;
            end
        end
        @(negedge clk); #3;
        chk_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
